ld_stream_dispatch: RTL and testbench
=====================================

// Module: ld_stream_dispatch
// PURPOSE
// - Upstream feeder of the tile-load controller. Accepts one tile command (act/BS-wgt/BP-wgt beat counts) and one
//   ready/valid data stream from the DMA, then frames each tile for the controller:
//   ld_tile_start pulse -> act beats -> BS wgt beats -> BP wgt beats -> wait ld_tile_end -> tile_done.
// - Drives the controller's bw_*_times inputs, holding them stable for the whole tile.
// PARAMETERS
// - DATA_W  512  width of a stream beat / buffer load word
// - CNT_W   16   beat-count width; must match controller count ports
// PORTS
// - clk               in   1       clock
// - rst_n             in   1       synchronous, active-low reset
// - cmd_valid         in   1       tile command valid
// - cmd_ready         out  1       high only in IDLE
// - cmd_act_times     in   CNT_W   act beats in tile
// - cmd_bs_wgt_times  in   CNT_W   BS wgt beats
// - cmd_bp_wgt_times  in   CNT_W   BP wgt beats
// - s_data            in   DATA_W  stream beat
// - s_valid           in   1       stream valid
// - s_ready           out  1       stream ready
// - bw_act_times      out  CNT_W   latched act count to controller
// - bs_bw_wgt_times   out  CNT_W   latched BS wgt count
// - bp_bw_wgt_times   out  CNT_W   latched BP wgt count
// - ld_tile_start     out  1       1-cycle tile start pulse
// - ld_valid_act      out  1       act beat on ld_data
// - ld_valid_wgt      out  1       wgt beat on ld_data
// - ld_data           out  DATA_W  registered beat to buffers
// - ld_tile_end       in   1       controller reports tile loaded
// - tile_done         out  1       1-cycle pulse, tile complete
// - err_zero_len      out  1       1-cycle pulse, command rejected
// - busy              out  1       state != IDLE
// BEHAVIOUR
// - Reset: state IDLE; all valids/pulses 0, ld_data 0, bw_*/bs_*/bp_* counts 0, beat counter 0.
// - FSM: IDLE, START, ACT, BS_WGT, BP_WGT, WAIT_END.
// - IDLE: cmd_ready=1; on cmd_valid latch all 3 counts into count outputs. Any count == 0 -> err_zero_len
//   next cycle, stay IDLE, counts still updated; else -> START.
// - START: ld_tile_start=1 for exactly this cycle, s_ready=0 -> ACT.
// - ACT/BS_WGT/BP_WGT: s_ready=1. Beat = s_valid&s_ready; beat_cnt++.
//   On beat with beat_cnt == times-1: beat_cnt<=0, advance to next state.
// - Output regs: beat -> next cycle ld_data=s_data; ld_valid_act=1 (ACT) or ld_valid_wgt=1 (BS/BP); else valids 0.
//   ld_data holds last value when idle. Latency: 1 cycle from handshake to ld_valid_*.
// - No backpressure from controller: every ld_valid_* cycle is consumed.
// - First beat is never emitted before cycle start+2, so the controller load states are already armed.
// - Gaps (s_valid=0) are legal anywhere; they only stall.
// - BP_WGT last beat -> WAIT_END; s_ready=0. On ld_tile_end=1: tile_done=1 next cycle -> IDLE.
// - ld_tile_end in any other state is ignored. cmd_valid outside IDLE is ignored (cmd_ready=0).
// - Count outputs change only on command accept; stable from START through WAIT_END.
// - Reset mid-tile: abort immediately to reset values; a partial tile is not resumed.
// - Max tile: 65535 beats per phase; beat_cnt never wraps (cleared at phase end).
// CONFIGURATION
// - LD_DISPATCH_PERF_EN defined: adds output perf_stall_cnt [31:0].
//   - Increments each cycle in ACT/BS_WGT/BP_WGT with s_valid=0.
//   - Saturates at 0xFFFF_FFFF; cleared only by reset.
// - Not defined: port and counter absent; all other behaviour identical.
// TESTING
// - cmd (4,2,3), s_valid always 1 -> start@T; ld_valid_act@T+2..T+5; ld_valid_wgt@T+6..T+10;
//   data order preserved; tile_done one cycle after ld_tile_end.
// - cmd (3,1,1), s_valid toggling 1010... -> 5 beats total, no drops/dups;
//   busy until tile_done; with PERF_EN perf_stall_cnt=4.
// - cmd (0,2,2) -> err_zero_len pulse 1 cycle; no ld_tile_start; cmd_ready stays 1; next valid cmd runs normally.
// - cmd_valid held high during tile -> accepted only after tile_done; counts stable through tile.
// - rst_n low mid-BS_WGT -> next cycle all outputs at reset values; new cmd (1,1,1) completes normally.
// - Stray ld_tile_end during ACT -> ignored; tile_done only after WAIT_END + ld_tile_end.

Source files
------------

// File: rtl/ld_stream_dispatch.sv
// ld_stream_dispatch: frames one tile command plus a DMA beat stream into start/act/wgt/done for the tile-load controller.
// Optional LD_DISPATCH_PERF_EN adds perf_stall_cnt, counting stream-starved cycles inside the beat phases.
module ld_stream_dispatch #(
    parameter int DATA_W = 512,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_act_times,
    input  logic [CNT_W-1:0]  cmd_bs_wgt_times,
    input  logic [CNT_W-1:0]  cmd_bp_wgt_times,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [CNT_W-1:0]  bw_act_times,
    output logic [CNT_W-1:0]  bs_bw_wgt_times,
    output logic [CNT_W-1:0]  bp_bw_wgt_times,
    output logic              ld_tile_start,
    output logic              ld_valid_act,
    output logic              ld_valid_wgt,
    output logic [DATA_W-1:0] ld_data,
    input  logic              ld_tile_end,
    output logic              tile_done,
    output logic              err_zero_len,
`ifdef LD_DISPATCH_PERF_EN
    output logic [31:0]       perf_stall_cnt,
`endif
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, START, ACT, BS_WGT, BP_WGT, WAIT_END} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0]    act_q, bs_q, bp_q, cur_times;
    logic [DATA_W-1:0]   data_q;
    logic                vact_q, vwgt_q, done_q, err_q;
    logic                phase, beat, last, accept, zero_len;

    assign phase     = (state_q == ACT) || (state_q == BS_WGT) || (state_q == BP_WGT);
    assign cur_times = (state_q == ACT) ? act_q : (state_q == BS_WGT) ? bs_q : bp_q;
    assign beat      = s_valid && phase;
    assign last      = beat && (beat_cnt_q == cur_times - CNT_W'(1));
    assign accept    = (state_q == IDLE) && cmd_valid;
    assign zero_len  = (cmd_act_times == '0) || (cmd_bs_wgt_times == '0) || (cmd_bp_wgt_times == '0);

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat ? (last ? '0 : beat_cnt_q + CNT_W'(1)) : beat_cnt_q;
        case (state_q)
            IDLE:     state_d = (accept && !zero_len) ? START : IDLE;
            START:    state_d = ACT;
            ACT:      state_d = last ? BS_WGT : ACT;
            BS_WGT:   state_d = last ? BP_WGT : BS_WGT;
            BP_WGT:   state_d = last ? WAIT_END : BP_WGT;
            WAIT_END: state_d = ld_tile_end ? IDLE : WAIT_END;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            act_q      <= '0;
            bs_q       <= '0;
            bp_q       <= '0;
            data_q     <= '0;
            vact_q     <= 1'b0;
            vwgt_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            // Counts are latched even for a rejected command so the controller sees what was asked for.
            if (accept) begin
                act_q <= cmd_act_times;
                bs_q  <= cmd_bs_wgt_times;
                bp_q  <= cmd_bp_wgt_times;
            end
            if (beat) data_q <= s_data;
            vact_q <= beat && (state_q == ACT);
            vwgt_q <= beat && (state_q != ACT);
            done_q <= (state_q == WAIT_END) && ld_tile_end;
            err_q  <= accept && zero_len;
        end
    end

`ifdef LD_DISPATCH_PERF_EN
    logic [31:0] stall_q;
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else if (phase && !s_valid && stall_q != 32'hFFFF_FFFF) stall_q <= stall_q + 32'd1;
    end
    assign perf_stall_cnt = stall_q;
`endif

    assign cmd_ready       = (state_q == IDLE);
    assign s_ready         = phase;
    assign busy            = (state_q != IDLE);
    assign ld_tile_start   = (state_q == START);
    assign ld_valid_act    = vact_q;
    assign ld_valid_wgt    = vwgt_q;
    assign ld_data         = data_q;
    assign tile_done       = done_q;
    assign err_zero_len    = err_q;
    assign bw_act_times    = act_q;
    assign bs_bw_wgt_times = bs_q;
    assign bp_bw_wgt_times = bp_q;
endmodule

// File: tb/tb_ld_stream_dispatch.sv
// tb_ld_stream_dispatch: directed checks of tile framing, gaps, zero-length rejection, held commands and mid-tile reset.
module tb_ld_stream_dispatch;
    localparam int DW = 512;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [CW-1:0] cmd_act_times = '0, cmd_bs_wgt_times = '0, cmd_bp_wgt_times = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [CW-1:0] bw_act_times, bs_bw_wgt_times, bp_bw_wgt_times;
    logic          ld_tile_start, ld_valid_act, ld_valid_wgt;
    logic [DW-1:0] ld_data;
    logic          ld_tile_end = 1'b0;
    logic          tile_done, err_zero_len, busy;
`ifdef LD_DISPATCH_PERF_EN
    logic [31:0]   perf_stall_cnt;
`endif

    int n_assert = 0;
    int n_fail = 0;
    int seq = 5000;

    ld_stream_dispatch #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_act_times(cmd_act_times), .cmd_bs_wgt_times(cmd_bs_wgt_times), .cmd_bp_wgt_times(cmd_bp_wgt_times),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .bw_act_times(bw_act_times), .bs_bw_wgt_times(bs_bw_wgt_times), .bp_bw_wgt_times(bp_bw_wgt_times),
        .ld_tile_start(ld_tile_start), .ld_valid_act(ld_valid_act), .ld_valid_wgt(ld_valid_wgt),
        .ld_data(ld_data), .ld_tile_end(ld_tile_end), .tile_done(tile_done), .err_zero_len(err_zero_len),
`ifdef LD_DISPATCH_PERF_EN
        .perf_stall_cnt(perf_stall_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic chk_counts(input int a, input int b, input int p);
        chk("act_times", 32'(bw_act_times), 32'(a));
        chk("bs_times", 32'(bs_bw_wgt_times), 32'(b));
        chk("bp_times", 32'(bp_bw_wgt_times), 32'(p));
    endtask

    task automatic cmd(input int a, input int b, input int p);
        cmd_valid = 1'b1;
        cmd_act_times = CW'(a);
        cmd_bs_wgt_times = CW'(b);
        cmd_bp_wgt_times = CW'(p);
    endtask

    // Entered on the START cycle; scoreboards every accepted beat against what comes out, in order.
    task automatic run_tile(input int a, input int b, input int p, input bit tog);
        logic [DW-1:0] q[$];
        logic [DW-1:0] e;
        int na = 0;
        int nw = 0;
        for (int c = 0; c < 400 && na + nw < a + b + p; c++) begin
            s_valid = tog ? (c % 2 == 1) : 1'b1;
            s_data = {16{32'(seq)}};
            seq++;
            if (s_valid && s_ready) q.push_back(s_data);
            @(negedge clk);
            chk("busy_in_tile", 32'(busy), 1);
            chk("no_restart", 32'(ld_tile_start), 0);
            chk_counts(a, b, p);
            if (ld_valid_act || ld_valid_wgt) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                chkd("beat_data", ld_data, e);
                chk("beat_is_act", 32'(ld_valid_act), 32'(na < a));
                chk("valid_exclusive", 32'(ld_valid_act & ld_valid_wgt), 0);
                if (ld_valid_act) na++;
                else nw++;
            end
        end
        chk("act_beats", 32'(na), 32'(a));
        chk("wgt_beats", 32'(nw), 32'(b + p));
        s_valid = 1'b0;
        ld_tile_end = 1'b1;
        @(negedge clk);
        ld_tile_end = 1'b0;
        chk("tile_done_pulse", 32'(tile_done), 1);
        chk("idle_after_done", 32'(busy), 0);
        chk("ready_after_done", 32'(cmd_ready), 1);
        @(negedge clk);
        chk("tile_done_cleared", 32'(tile_done), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_valids", 32'({ld_valid_act, ld_valid_wgt, ld_tile_start, tile_done, err_zero_len}), 0);
        chkd("rst_data", ld_data, '0);
        chk_counts(0, 0, 0);
        rst_n = 1'b1;

        // (4,2,3) with continuous stream; exact timing, stray tile_end in ACT, and a held next command.
        cmd(4, 2, 3);
        s_valid = 1'b1;
        s_data = {16{32'd999}};
        @(negedge clk);
        for (int c = 0; c <= 12; c++) begin
            chk("t1_start", 32'(ld_tile_start), 32'(c == 0));
            chk("t1_valid_act", 32'(ld_valid_act), 32'(c >= 2 && c <= 5));
            chk("t1_valid_wgt", 32'(ld_valid_wgt), 32'(c >= 6 && c <= 10));
            if (c >= 2 && c <= 10) chkd("t1_data", ld_data, {16{32'(1000 + c - 1)}});
            chk("t1_tile_done", 32'(tile_done), 32'(c == 12));
            chk("t1_busy", 32'(busy), 32'(c < 12));
            chk("t1_cmd_ready", 32'(cmd_ready), 32'(c == 12));
            chk_counts(4, 2, 3);
            cmd(1, 1, 1);
            s_data = {16{32'(1000 + c)}};
            ld_tile_end = (c == 2 || c == 11);
            @(negedge clk);
        end
        ld_tile_end = 1'b0;
        chk("held_cmd_start", 32'(ld_tile_start), 1);
        chk("held_tile_done_cleared", 32'(tile_done), 0);
        chk_counts(1, 1, 1);
        cmd_valid = 1'b0;
        run_tile(1, 1, 1, 1'b0);
`ifdef LD_DISPATCH_PERF_EN
        chk("perf_no_stall", perf_stall_cnt, 0);
`endif

        // (3,1,1) with a 1010... stream.
        cmd(3, 1, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("t2_start", 32'(ld_tile_start), 1);
        run_tile(3, 1, 1, 1'b1);
`ifdef LD_DISPATCH_PERF_EN
        chk("perf_stall_4", perf_stall_cnt, 4);
`endif

        // Zero-length command is rejected but its counts are still latched.
        cmd(0, 2, 2);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("zl_err", 32'(err_zero_len), 1);
        chk("zl_cmd_ready", 32'(cmd_ready), 1);
        chk("zl_busy", 32'(busy), 0);
        chk("zl_no_start", 32'(ld_tile_start), 0);
        chk_counts(0, 2, 2);
        @(negedge clk);
        chk("zl_err_cleared", 32'(err_zero_len), 0);
        chk("zl_still_no_start", 32'(ld_tile_start), 0);
        cmd(2, 1, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("zl_next_start", 32'(ld_tile_start), 1);
        run_tile(2, 1, 1, 1'b0);

        // Reset lands while the BS phase is consuming.
        cmd(2, 3, 2);
        s_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_act", 32'(ld_valid_act), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_valids", 32'({ld_valid_act, ld_valid_wgt, ld_tile_start, tile_done, err_zero_len}), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_ready", 32'(cmd_ready), 1);
        chkd("mid_rst_data", ld_data, '0);
        chk_counts(0, 0, 0);
`ifdef LD_DISPATCH_PERF_EN
        chk("mid_rst_perf", perf_stall_cnt, 0);
`endif
        rst_n = 1'b1;
        s_valid = 1'b0;
        cmd(1, 1, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("post_rst_start", 32'(ld_tile_start), 1);
        run_tile(1, 1, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end
endmodule
